crono_countdown: RTL and testbench

Run-time engine of the chronometer. Takes the BCD hours/minutes/seconds value produced by the time-setting stage, counts it down once per second and flags expiry. Sits directly downstream of the setting stage; its BCD outputs feed the display multiplexer and its `alarm` output drives the buzzer logic.

---
 rtl/crono_pkg.sv | 30 +++
 rtl/crono_tick_gen.sv | 43 ++++
 rtl/crono_countdown.sv | 174 +++++++++++++++++
 tb/tb_crono_countdown.sv | 249 ++++++++++++++++++++++++
 4 files changed

// File: rtl/crono_pkg.sv
// rtl/crono_pkg.sv - shared constants, state encoding and load clamp for the chronometer
//
// Purpose : BCD field limits, IDLE/RUN state encoding and the bcd_clamp
//           helper used when capturing set values.
// Ports   : none (package).
// Config  : none here; the alarm latch in crono_countdown is built only when
//           CRONO_ALARM_EN is defined.

package crono_pkg;

  localparam logic [7:0] H_MAX  = 8'h23;
  localparam logic [7:0] MS_MAX = 8'h59;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } state_t;

  // A units digit above 9 or any value above the field maximum loads as the
  // maximum. With the units digit already valid, "value > max" also catches
  // a tens digit above its limit.
  function automatic logic [7:0] bcd_clamp(input logic [7:0] i_val,
                                           input logic [7:0] i_max);
    if ((i_val[3:0] > 4'd9) || (i_val > i_max)) begin
      return i_max;
    end
    return i_val;
  endfunction

endpackage

// File: rtl/crono_tick_gen.sv
// rtl/crono_tick_gen.sv - one-second prescaler producing a single-cycle tick
//
// Purpose : counts 0..TICK_DIV-1 while enabled; o_tick is high during the
//           cycle in which the count equals TICK_DIV-1, so the consumer acts
//           on the same edge that returns the prescaler to 0.
// Ports   : clk, reset    - clock, synchronous active-high reset
//           i_clear       - force the prescaler to 0 (wins over i_enable)
//           i_enable      - advance the prescaler
//           o_tick        - one-cycle tick (combinational from the register)
// Config  : none.

module crono_tick_gen #(
  parameter int TICK_DIV = 100_000_000
) (
  input  logic clk,
  input  logic reset,
  input  logic i_clear,
  input  logic i_enable,
  output logic o_tick
);

  localparam int CW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [CW-1:0] LAST = CW'(TICK_DIV - 1);

  logic [CW-1:0] r_cnt;
  logic          w_at_last;

  assign w_at_last = (r_cnt == LAST);
  assign o_tick    = i_enable && w_at_last;

  always_ff @(posedge clk) begin
    if (reset || i_clear) begin
      r_cnt <= '0;
    end else if (i_enable) begin
      if (w_at_last) begin
        r_cnt <= '0;
      end else begin
        r_cnt <= r_cnt + CW'(1);
      end
    end
  end

endmodule

// File: rtl/crono_countdown.sv
// rtl/crono_countdown.sv - BCD hh:mm:ss countdown engine with expiry flag
//
// Purpose : captures a BCD time, counts it down once per tick and flags
//           reaching 00:00:00.
// Ports   : clk, reset               - clock, synchronous active-high reset
//           i_load                   - capture i_set_h/m/s (clamped), go IDLE
//           i_set_h/i_set_m/i_set_s  - BCD load values
//           i_start / i_stop         - begin/resume and pause pulses
//           i_alarm_ack              - clear o_alarm (CRONO_ALARM_EN build)
//           o_cnt_h/o_cnt_m/o_cnt_s  - current BCD count
//           o_running                - high while in RUN
//           o_done                   - one-cycle pulse with the 00:00:00 update
//           o_alarm                  - latched expiry (0 unless CRONO_ALARM_EN)
// Config  : CRONO_ALARM_EN enables the alarm latch.

module crono_countdown
  import crono_pkg::*;
#(
  parameter int TICK_DIV = 100_000_000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       i_load,
  input  logic [7:0] i_set_h,
  input  logic [7:0] i_set_m,
  input  logic [7:0] i_set_s,
  input  logic       i_start,
  input  logic       i_stop,
  input  logic       i_alarm_ack,
  output logic [7:0] o_cnt_h,
  output logic [7:0] o_cnt_m,
  output logic [7:0] o_cnt_s,
  output logic       o_running,
  output logic       o_done,
  output logic       o_alarm
);

  state_t     r_state, w_next_state;
  logic [7:0] r_h, r_m, r_s;
  logic       r_done;
  logic       w_tick, w_clear, w_decrement, w_expire;
  logic       w_zero, w_last;
  logic [7:0] w_dec_h, w_dec_m, w_dec_s;

  crono_tick_gen #(.TICK_DIV(TICK_DIV)) u_tick_gen (
    .clk      (clk),
    .reset    (reset),
    .i_clear  (w_clear),
    .i_enable (r_state == ST_RUN),
    .o_tick   (w_tick)
  );

  assign w_zero = ({r_h, r_m, r_s} == 24'h00_00_00);
  assign w_last = ({r_h, r_m, r_s} == 24'h00_00_01);

  // BCD borrow chain. Hours never borrow past 00 because RUN is never
  // entered or kept with a zero count.
  always_comb begin
    w_dec_h = r_h;
    w_dec_m = r_m;
    w_dec_s = r_s;
    if (r_s[3:0] != 4'd0) begin
      w_dec_s[3:0] = r_s[3:0] - 4'd1;
    end else begin
      w_dec_s[3:0] = 4'd9;
      if (r_s[7:4] != 4'd0) begin
        w_dec_s[7:4] = r_s[7:4] - 4'd1;
      end else begin
        w_dec_s[7:4] = 4'd5;
        if (r_m[3:0] != 4'd0) begin
          w_dec_m[3:0] = r_m[3:0] - 4'd1;
        end else begin
          w_dec_m[3:0] = 4'd9;
          if (r_m[7:4] != 4'd0) begin
            w_dec_m[7:4] = r_m[7:4] - 4'd1;
          end else begin
            w_dec_m[7:4] = 4'd5;
            if (r_h[3:0] != 4'd0) begin
              w_dec_h[3:0] = r_h[3:0] - 4'd1;
            end else begin
              w_dec_h[3:0] = 4'd9;
              w_dec_h[7:4] = r_h[7:4] - 4'd1;
            end
          end
        end
      end
    end
  end

  // Priority: load > stop > start; a stop or load on a tick edge suppresses
  // the decrement.
  always_comb begin
    w_next_state = r_state;
    w_clear      = 1'b0;
    w_decrement  = 1'b0;
    w_expire     = 1'b0;
    if (i_load) begin
      w_next_state = ST_IDLE;
      w_clear      = 1'b1;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (i_start && !w_zero) begin
            w_next_state = ST_RUN;
            w_clear      = 1'b1;
          end
        end
        ST_RUN: begin
          if (i_stop) begin
            w_next_state = ST_IDLE;
            w_clear      = 1'b1;
          end else if (w_tick) begin
            w_decrement = 1'b1;
            if (w_last) begin
              w_expire     = 1'b1;
              w_next_state = ST_IDLE;
            end
          end
        end
        default: w_next_state = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= ST_IDLE;
      r_h     <= 8'h00;
      r_m     <= 8'h00;
      r_s     <= 8'h00;
      r_done  <= 1'b0;
    end else begin
      r_state <= w_next_state;
      r_done  <= w_expire;
      if (i_load) begin
        r_h <= bcd_clamp(i_set_h, H_MAX);
        r_m <= bcd_clamp(i_set_m, MS_MAX);
        r_s <= bcd_clamp(i_set_s, MS_MAX);
      end else if (w_decrement) begin
        r_h <= w_dec_h;
        r_m <= w_dec_m;
        r_s <= w_dec_s;
      end
    end
  end

`ifdef CRONO_ALARM_EN
  logic r_alarm;

  // Expiry outranks a simultaneous acknowledge.
  always_ff @(posedge clk) begin
    if (reset || i_load) begin
      r_alarm <= 1'b0;
    end else if (w_expire) begin
      r_alarm <= 1'b1;
    end else if (i_alarm_ack) begin
      r_alarm <= 1'b0;
    end
  end

  assign o_alarm = r_alarm;
`else
  logic w_unused_ack;
  assign w_unused_ack = i_alarm_ack;
  assign o_alarm      = 1'b0;
`endif

  assign o_cnt_h   = r_h;
  assign o_cnt_m   = r_m;
  assign o_cnt_s   = r_s;
  assign o_running = (r_state == ST_RUN);
  assign o_done    = r_done;

endmodule

// File: tb/tb_crono_countdown.sv
// tb/tb_crono_countdown.sv - directed self-checking bench for crono_countdown (TICK_DIV=4)

module tb_crono_countdown;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       i_load = 1'b0;
  logic [7:0] i_set_h = 8'h00;
  logic [7:0] i_set_m = 8'h00;
  logic [7:0] i_set_s = 8'h00;
  logic       i_start = 1'b0;
  logic       i_stop = 1'b0;
  logic       i_alarm_ack = 1'b0;
  logic [7:0] o_cnt_h, o_cnt_m, o_cnt_s;
  logic       o_running, o_done, o_alarm;

  int total = 0;
  int bad = 0;

`ifdef CRONO_ALARM_EN
  localparam logic ALARM_ON = 1'b1;
`else
  localparam logic ALARM_ON = 1'b0;
`endif

  crono_countdown #(.TICK_DIV(4)) dut (
    .clk         (clk),
    .reset       (reset),
    .i_load      (i_load),
    .i_set_h     (i_set_h),
    .i_set_m     (i_set_m),
    .i_set_s     (i_set_s),
    .i_start     (i_start),
    .i_stop      (i_stop),
    .i_alarm_ack (i_alarm_ack),
    .o_cnt_h     (o_cnt_h),
    .o_cnt_m     (o_cnt_m),
    .o_cnt_s     (o_cnt_s),
    .o_running   (o_running),
    .o_done      (o_done),
    .o_alarm     (o_alarm)
  );

  always #5 clk = ~clk;

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic do_load(input logic [23:0] v);
    {i_set_h, i_set_m, i_set_s} = v;
    i_load = 1'b1;
    cyc();
    i_load = 1'b0;
  endtask

  task automatic do_start();
    i_start = 1'b1;
    cyc();
    i_start = 1'b0;
  endtask

  task automatic do_stop();
    i_stop = 1'b1;
    cyc();
    i_stop = 1'b0;
  endtask

  task automatic test_reset();
    int done_seen = 0;
    reset = 1'b1;
    cyc();
    cyc();
    reset = 1'b0;
    for (int i = 0; i < 20; i++) begin
      cyc();
      if (o_done) done_seen++;
    end
    total++;
    if ({o_cnt_h, o_cnt_m, o_cnt_s} !== 24'h000000) begin
      bad++; $display("FAIL reset_count: got %h exp 000000", {o_cnt_h, o_cnt_m, o_cnt_s});
    end
    total++;
    if ({o_running, o_alarm} !== 2'b00 || done_seen != 0) begin
      bad++; $display("FAIL reset_flags: running=%b alarm=%b done_cycles=%0d exp 0 0 0", o_running, o_alarm, done_seen);
    end
  endtask

  task automatic test_expiry();
    logic [7:0] exp_s;
    do_load(24'h000003);
    do_start();
    total++;
    if (o_running !== 1'b1 || o_cnt_s !== 8'h03) begin
      bad++; $display("FAIL exp_start: running=%b s=%h exp 1 03", o_running, o_cnt_s);
    end
    for (int k = 1; k <= 12; k++) begin
      cyc();
      exp_s = 8'(3 - k / 4);
      total++;
      if ({o_cnt_h, o_cnt_m, o_cnt_s} !== {16'h0000, exp_s} || o_done !== (k == 12)
          || o_running !== (k < 12) || o_alarm !== (ALARM_ON && k == 12)) begin
        bad++;
        $display("FAIL exp_cycle%0d: cnt=%h done=%b run=%b alarm=%b exp cnt=0000%h done=%b run=%b alarm=%b",
                 k, {o_cnt_h, o_cnt_m, o_cnt_s}, o_done, o_running, o_alarm,
                 exp_s, (k == 12), (k < 12), (ALARM_ON && k == 12));
      end
    end
    cyc();
    cyc();
    total++;
    if (o_done !== 1'b0 || o_alarm !== ALARM_ON || o_running !== 1'b0) begin
      bad++; $display("FAIL exp_after: done=%b alarm=%b run=%b exp 0 %b 0", o_done, o_alarm, o_running, ALARM_ON);
    end
    i_alarm_ack = 1'b1;
    cyc();
    i_alarm_ack = 1'b0;
    total++;
    if (o_alarm !== 1'b0) begin
      bad++; $display("FAIL exp_ack: alarm=%b exp 0", o_alarm);
    end
  endtask

  task automatic test_borrow();
    do_load(24'h010000);
    do_start();
    for (int i = 0; i < 4; i++) cyc();
    total++;
    if ({o_cnt_h, o_cnt_m, o_cnt_s} !== 24'h005959) begin
      bad++; $display("FAIL borrow_1: got %h exp 005959", {o_cnt_h, o_cnt_m, o_cnt_s});
    end
    for (int i = 0; i < 4; i++) cyc();
    total++;
    if ({o_cnt_h, o_cnt_m, o_cnt_s} !== 24'h005958 || o_running !== 1'b1) begin
      bad++; $display("FAIL borrow_2: got %h run=%b exp 005958 1", {o_cnt_h, o_cnt_m, o_cnt_s}, o_running);
    end
    do_stop();
  endtask

  task automatic test_stop_resume();
    int held_bad = 0;
    do_load(24'h000010);
    do_start();
    cyc();
    do_stop();
    for (int i = 0; i < 12; i++) begin
      cyc();
      if (o_cnt_s !== 8'h10 || o_running !== 1'b0) held_bad++;
    end
    total++;
    if (held_bad != 0) begin
      bad++; $display("FAIL stop_hold: bad_cycles=%0d exp 0 (last s=%h run=%b)", held_bad, o_cnt_s, o_running);
    end
    do_start();
    for (int i = 0; i < 3; i++) cyc();
    total++;
    if (o_cnt_s !== 8'h10 || o_running !== 1'b1) begin
      bad++; $display("FAIL resume_pre: s=%h run=%b exp 10 1", o_cnt_s, o_running);
    end
    cyc();
    total++;
    if (o_cnt_s !== 8'h09) begin
      bad++; $display("FAIL resume_dec: s=%h exp 09", o_cnt_s);
    end
    do_stop();
  endtask

  task automatic test_clamp_zero();
    int err = 0;
    do_load(24'h9A750F);
    total++;
    if ({o_cnt_h, o_cnt_m, o_cnt_s} !== 24'h235959 || o_running !== 1'b0) begin
      bad++; $display("FAIL clamp: got %h run=%b exp 235959 0", {o_cnt_h, o_cnt_m, o_cnt_s}, o_running);
    end
    do_load(24'h245960);
    total++;
    if ({o_cnt_h, o_cnt_m, o_cnt_s} !== 24'h235959) begin
      bad++; $display("FAIL clamp_edge: got %h exp 235959", {o_cnt_h, o_cnt_m, o_cnt_s});
    end
    do_load(24'h000000);
    do_start();
    for (int i = 0; i < 10; i++) begin
      if (o_running !== 1'b0 || o_done !== 1'b0) err++;
      cyc();
    end
    total++;
    if (err != 0 || {o_cnt_h, o_cnt_m, o_cnt_s} !== 24'h000000) begin
      bad++; $display("FAIL zero_start: bad_cycles=%0d cnt=%h exp 0 000000", err, {o_cnt_h, o_cnt_m, o_cnt_s});
    end
  endtask

  task automatic test_priority();
    do_load(24'h000009);
    do_start();
    for (int i = 0; i < 3; i++) cyc();
    // next edge is a tick edge
    {i_set_h, i_set_m, i_set_s} = 24'h000005;
    i_load = 1'b1;
    i_stop = 1'b1;
    i_start = 1'b1;
    cyc();
    i_load = 1'b0;
    i_stop = 1'b0;
    i_start = 1'b0;
    total++;
    if ({o_cnt_h, o_cnt_m, o_cnt_s} !== 24'h000005 || o_running !== 1'b0
        || o_done !== 1'b0 || o_alarm !== 1'b0) begin
      bad++; $display("FAIL prio: cnt=%h run=%b done=%b alarm=%b exp 000005 0 0 0",
                      {o_cnt_h, o_cnt_m, o_cnt_s}, o_running, o_done, o_alarm);
    end
    for (int i = 0; i < 6; i++) cyc();
    total++;
    if (o_cnt_s !== 8'h05 || o_running !== 1'b0) begin
      bad++; $display("FAIL prio_hold: s=%h run=%b exp 05 0", o_cnt_s, o_running);
    end
  endtask

  task automatic test_reset_mid();
    do_load(24'h000009);
    do_start();
    for (int i = 0; i < 5; i++) cyc();
    total++;
    if (o_cnt_s !== 8'h08) begin
      bad++; $display("FAIL mid_pre: s=%h exp 08", o_cnt_s);
    end
    reset = 1'b1;
    cyc();
    reset = 1'b0;
    total++;
    if ({o_cnt_h, o_cnt_m, o_cnt_s} !== 24'h000000 || o_running !== 1'b0 || o_done !== 1'b0) begin
      bad++; $display("FAIL mid_reset: cnt=%h run=%b done=%b exp 000000 0 0",
                      {o_cnt_h, o_cnt_m, o_cnt_s}, o_running, o_done);
    end
  endtask

  initial begin
    test_reset();
    test_expiry();
    test_borrow();
    test_stop_resume();
    test_clamp_zero();
    test_priority();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
